// File: rtl/ibex_pkg.sv
// +----------------------------------------------------------------------+
// | ibex_pkg: shared writeback-stage instruction type encoding            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ibex_pkg;

  // Encoding 2'd3 is illegal and is handled as OTHER by consumers.
  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

endpackage

`default_nettype wire

// File: rtl/ibex_wb_pipe.sv
// +----------------------------------------------------------------------+
// | ibex_wb_pipe: single-entry writeback stage with retire counter        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ibex_wb_pipe
  import ibex_pkg::*;
#(
  parameter bit          ResetAll    = 1'b0,
  parameter int unsigned RetCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   en_wb_i,
  input  logic [1:0]             instr_type_wb_i,
  input  logic [4:0]             rf_waddr_id_i,
  input  logic [31:0]            rf_wdata_id_i,
  input  logic                   rf_we_id_i,

  input  logic                   lsu_resp_valid_i,
  input  logic                   lsu_resp_err_i,
  input  logic [31:0]            rf_wdata_lsu_i,

  output logic                   ready_wb_o,
  output logic [4:0]             rf_waddr_wb_o,
  output logic [31:0]            rf_wdata_wb_o,
  output logic                   rf_we_wb_o,
  output logic                   rf_write_wb_o,
  output logic [31:0]            rf_wdata_fwd_wb_o,
  output logic                   outstanding_load_wb_o,
  output logic                   outstanding_store_wb_o,
  output logic                   instr_done_wb_o,
  output logic [RetCntWidth-1:0] ret_count_o
);

  localparam logic [RetCntWidth-1:0] RetCntOne = RetCntWidth'(1);

  logic                   wb_valid_q, wb_valid_d;
  logic [1:0]             wb_type_q;
  logic                   wb_we_q;
  logic [4:0]             wb_rd_q;
  logic [31:0]            wb_wdata_q;
  logic [RetCntWidth-1:0] ret_cnt_q, ret_cnt_d;

  logic wb_is_load;
  logic wb_is_store;
  logic wb_is_other;
  logic wb_done;
  logic wb_accept;
  logic wb_rd_nonzero;

  assign wb_is_load    = (wb_type_q == WB_INSTR_LOAD);
  assign wb_is_store   = (wb_type_q == WB_INSTR_STORE);
  assign wb_is_other   = ~wb_is_load & ~wb_is_store;
  assign wb_rd_nonzero = (wb_rd_q != 5'd0);

  // Memory ops wait for the LSU; everything else retires one cycle after capture.
  assign wb_done    = wb_valid_q & (wb_is_other | lsu_resp_valid_i);
  assign ready_wb_o = ~wb_valid_q | wb_done;
  assign wb_accept  = en_wb_i & ready_wb_o;

  always_comb begin
    wb_valid_d = wb_valid_q;
    if (wb_accept) begin
      wb_valid_d = 1'b1;
    end else if (wb_done) begin
      wb_valid_d = 1'b0;
    end
  end

  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (wb_done && (ret_cnt_q != {RetCntWidth{1'b1}})) begin
      ret_cnt_d = ret_cnt_q + RetCntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_type_q  <= WB_INSTR_OTHER;
      wb_we_q    <= 1'b0;
      ret_cnt_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      ret_cnt_q  <= ret_cnt_d;
      if (wb_accept) begin
        wb_type_q <= instr_type_wb_i;
        wb_we_q   <= rf_we_id_i;
      end
    end
  end

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wb_rd_q    <= 5'd0;
        wb_wdata_q <= 32'd0;
      end else if (wb_accept) begin
        wb_rd_q    <= rf_waddr_id_i;
        wb_wdata_q <= rf_wdata_id_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (wb_accept) begin
        wb_rd_q    <= rf_waddr_id_i;
        wb_wdata_q <= rf_wdata_id_i;
      end
    end
  end

  assign rf_waddr_wb_o     = wb_rd_q;
  assign rf_wdata_wb_o     = wb_is_load ? rf_wdata_lsu_i : wb_wdata_q;
  assign rf_wdata_fwd_wb_o = wb_wdata_q;

  // Stores never write rd, and an errored load retires without a write.
  assign rf_we_wb_o    = wb_done & wb_we_q & wb_rd_nonzero & ~wb_is_store &
                         ~(wb_is_load & lsu_resp_err_i);
  assign rf_write_wb_o = wb_valid_q & wb_we_q & wb_rd_nonzero & ~wb_is_store;

  assign outstanding_load_wb_o  = wb_valid_q & wb_is_load;
  assign outstanding_store_wb_o = wb_valid_q & wb_is_store;
  assign instr_done_wb_o        = wb_done;
  assign ret_count_o            = ret_cnt_q;

  a_no_en_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni) en_wb_i |-> ready_wb_o
  );

endmodule

`default_nettype wire

// File: tb/tb_ibex_wb_pipe.sv
// +----------------------------------------------------------------------+
// | tb_ibex_wb_pipe: directed + random checks of ibex_wb_pipe vs a model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ibex_wb_pipe;

  localparam int T_LOAD  = 0;
  localparam int T_STORE = 1;
  localparam int T_OTHER = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_wb_i;
  logic [1:0]  instr_type_wb_i;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic [31:0] rf_wdata_lsu_i;

  logic        ready0, we0, write0, oload0, ostore0, done0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0, fwd0;
  logic [15:0] cnt0;

  logic        ready1, we1, write1, oload1, ostore1, done1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1, fwd1;
  logic [3:0]  cnt1;

  always #5 clk_i = ~clk_i;

  ibex_wb_pipe #(.ResetAll(1'b0), .RetCntWidth(16)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
    .instr_type_wb_i(instr_type_wb_i), .rf_waddr_id_i(rf_waddr_id_i),
    .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_wdata_lsu_i(rf_wdata_lsu_i), .ready_wb_o(ready0),
    .rf_waddr_wb_o(waddr0), .rf_wdata_wb_o(wdata0), .rf_we_wb_o(we0),
    .rf_write_wb_o(write0), .rf_wdata_fwd_wb_o(fwd0),
    .outstanding_load_wb_o(oload0), .outstanding_store_wb_o(ostore0),
    .instr_done_wb_o(done0), .ret_count_o(cnt0)
  );

  ibex_wb_pipe #(.ResetAll(1'b1), .RetCntWidth(4)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
    .instr_type_wb_i(instr_type_wb_i), .rf_waddr_id_i(rf_waddr_id_i),
    .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_wdata_lsu_i(rf_wdata_lsu_i), .ready_wb_o(ready1),
    .rf_waddr_wb_o(waddr1), .rf_wdata_wb_o(wdata1), .rf_we_wb_o(we1),
    .rf_write_wb_o(write1), .rf_wdata_fwd_wb_o(fwd1),
    .outstanding_load_wb_o(oload1), .outstanding_store_wb_o(ostore1),
    .instr_done_wb_o(done1), .ret_count_o(cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: at most one pending instruction plus two retire tallies.
  bit          m_valid;
  int          m_type;
  bit [4:0]    m_rd;
  bit          m_we;
  bit [31:0]   m_data;
  int          m_cnt16;
  int          m_cnt4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int norm_type(input logic [1:0] t);
    if (t == 2'd0) return T_LOAD;
    if (t == 2'd1) return T_STORE;
    return T_OTHER;
  endfunction

  function automatic bit model_done(input bit rv);
    return m_valid && (m_type == T_OTHER || rv);
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_type  = T_OTHER;
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    en_wb_i = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i = 1'b0;
    rf_wdata_lsu_i = 32'd0;
    repeat (n) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, check both DUTs mid-cycle, then advance the model.
  task automatic cyc(input bit en, input logic [1:0] ty, input logic [4:0] rd,
                     input logic [31:0] d, input bit we, input bit rv,
                     input bit er, input logic [31:0] ld);
    bit done, ready, acc, exp_we, exp_write;
    done  = model_done(rv);
    ready = !m_valid || done;
    acc   = en && ready;
    en_wb_i = acc; instr_type_wb_i = ty; rf_waddr_id_i = rd;
    rf_wdata_id_i = d; rf_we_id_i = we;
    lsu_resp_valid_i = rv; lsu_resp_err_i = er; rf_wdata_lsu_i = ld;
    exp_we = done && m_we && (m_rd != 0) && (m_type != T_STORE) &&
             !(m_type == T_LOAD && er);
    exp_write = m_valid && m_we && (m_rd != 0) && (m_type != T_STORE);
    @(negedge clk_i);
    chk("ready", {31'd0, ready0}, {31'd0, ready});
    chk("rf_we", {31'd0, we0}, {31'd0, exp_we});
    chk("done", {31'd0, done0}, {31'd0, done});
    chk("rf_write", {31'd0, write0}, {31'd0, exp_write});
    chk("out_load", {31'd0, oload0}, {31'd0, m_valid && m_type == T_LOAD});
    chk("out_store", {31'd0, ostore0}, {31'd0, m_valid && m_type == T_STORE});
    chk("ret_cnt16", {16'd0, cnt0}, m_cnt16);
    chk("ret_cnt4", {28'd0, cnt1}, m_cnt4);
    chk("rf_we_r1", {31'd0, we1}, {31'd0, exp_we});
    chk("ready_r1", {31'd0, ready1}, {31'd0, ready});
    if (m_valid) begin
      chk("waddr", {27'd0, waddr0}, {27'd0, m_rd});
      chk("fwd", fwd0, m_data);
      chk("wdata", wdata0, (m_type == T_LOAD) ? ld : m_data);
    end
    @(posedge clk_i);
    #1;
    if (done) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (acc) begin
      m_valid = 1; m_type = norm_type(ty); m_rd = rd; m_we = we; m_data = d;
    end else if (done) begin
      m_valid = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd2, 5'd0, 32'd0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; en_wb_i = 1'b0; instr_type_wb_i = 2'd0;
    rf_waddr_id_i = 5'd0; rf_wdata_id_i = 32'd0; rf_we_id_i = 1'b0;
    lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0; rf_wdata_lsu_i = 32'd0;
    model_reset();

    do_reset(2);
    chk("rst_waddr_r1", {27'd0, waddr1}, 32'd0);
    chk("rst_fwd_r1", fwd1, 32'd0);
    chk("rst_wdata_r1", wdata1, 32'd0);
    chk("rst_write_r1", {31'd0, write1}, 32'd0);
    idle(1);

    cyc(1, 2'd2, 5'd5, 32'hDEADBEEF, 1, 0, 0, 32'd0);
    idle(2);

    for (int i = 1; i <= 3; i++) cyc(1, 2'd2, 5'(i), 32'h1000 + i, 1, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 2'd2, 5'd0, 32'h2000 + i, 1, 0, 0, 32'd0);
    idle(1);

    cyc(1, 2'd0, 5'd7, 32'hAAAA0000, 1, 0, 0, 32'd0);
    idle(3);
    cyc(1, 2'd2, 5'd8, 32'h0BADF00D, 1, 1, 0, 32'h12345678);
    idle(2);

    cyc(1, 2'd0, 5'd10, 32'h55, 1, 0, 0, 32'd0);
    cyc(0, 2'd2, 5'd0, 32'd0, 0, 1, 1, 32'hCAFEF00D);
    cyc(1, 2'd1, 5'd9, 32'h99, 1, 0, 0, 32'd0);
    cyc(0, 2'd2, 5'd0, 32'd0, 0, 1, 0, 32'h77);
    cyc(0, 2'd2, 5'd0, 32'd0, 0, 1, 0, 32'h88);
    idle(1);

    cyc(1, 2'd3, 5'd12, 32'h33, 1, 0, 0, 32'd0);
    for (int i = 0; i < 20; i++) cyc(1, 2'd2, 5'd3, 32'(i), 1, 0, 0, 32'd0);
    idle(1);
    chk("sat4", {28'd0, cnt1}, 32'd15);

    cyc(1, 2'd0, 5'd4, 32'h44, 1, 0, 0, 32'd0);
    cyc(0, 2'd2, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    do_reset(1);
    cyc(0, 2'd2, 5'd0, 32'd0, 0, 1, 0, 32'h1234);
    idle(1);
    chk("rst_cnt16", {16'd0, cnt0}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 31)), $urandom, bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 5) == 0),
          $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
